ahb_manager_arbiter: RTL and testbench

- Round-robin address-phase arbiter for the AHB multi-manager interconnect. It shares one downstream AHB bus among NUM_MANAGERS managers.
- Grants only at legal AHB boundaries: no regrant mid-burst, while locked, or while HREADY is low.
- Outputs a one-hot address-phase grant, its binary index, and the registered data-phase owner index. The interconnect uses these to drive its address and write-data muxes.

---
 rtl/ahb_pkg.sv | 15 +
 rtl/onehotdecoder.sv | 20 ++
 rtl/rr_pick.sv | 35 +++
 rtl/ahb_manager_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ahb_manager_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS encodings and the arbiter state type.
package ahb_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StOwned,
    StLocked
  } arb_state_t;

endpackage

// File: rtl/onehotdecoder.sv
// One-hot to binary index converter (OR of the indices of set bits).
module onehotdecoder #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = $clog2(Width)
) (
  input  logic [Width-1:0] onehot_i,
  output logic [IdxW-1:0]  idx_o
);

  // OR together the index of every set bit; exact when the input is one-hot
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < Width; i++) begin
      if (onehot_i[i]) begin
        idx_o = idx_o | IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first request at or above the pointer, wrapping.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;
  logic [IdxW:0]  gnt_base;
  logic           found;

  // Rotate so the pointer sits at bit 0, pick the lowest set bit, rotate back
  always_comb begin
    req_dbl  = {req_i, req_i};
    req_rot  = req_dbl[{1'b0, ptr_i} +: N];
    gnt_rot  = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        gnt_rot[i] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt_dbl  = {gnt_rot, gnt_rot};
    gnt_base = (IdxW + 1)'(N) - {1'b0, ptr_i};
    gnt_o    = gnt_dbl[gnt_base +: N];
  end

endmodule

// File: rtl/ahb_manager_arbiter.sv
// Round-robin AHB address-phase arbiter; regrants only at legal transfer boundaries.
module ahb_manager_arbiter #(
  parameter int unsigned NUM_MANAGERS = 4,
  parameter int unsigned MAX_TENURE   = 8
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [NUM_MANAGERS-1:0]         ManagerReq,
  input  logic [2*NUM_MANAGERS-1:0]       HTRANSM,
  input  logic [NUM_MANAGERS-1:0]         HMASTLOCKM,
  input  logic                            HREADY,
  output logic [NUM_MANAGERS-1:0]         GrantOneHot,
  output logic [$clog2(NUM_MANAGERS)-1:0] GrantIdx,
  output logic                            GrantValid,
  output logic [$clog2(NUM_MANAGERS)-1:0] DataOwnerIdx,
  output logic                            DataValid
);
  import ahb_pkg::*;

  localparam int unsigned           IdxW     = $clog2(NUM_MANAGERS);
  localparam logic [7:0]            MaxTen   = 8'(MAX_TENURE);
  localparam logic [NUM_MANAGERS-1:0] GrantRst = NUM_MANAGERS'(1);

  arb_state_t              state_q, state_d;
  logic [NUM_MANAGERS-1:0] grant_oh_q, grant_oh_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [7:0]              tenure_q, tenure_d;
  logic [IdxW-1:0]         data_idx_q, data_idx_d;
  logic                    data_valid_q, data_valid_d;

  logic [1:0]              owner_trans;
  logic                    owner_lock;
  logic                    owner_req;
  logic                    others_req;
  logic                    any_req;
  logic                    seq_busy;
  logic [NUM_MANAGERS-1:0] pick_oh;
  logic [IdxW-1:0]         pick_idx;
  logic                    pick_lock;
  logic [7:0]              tenure_eff;
  logic                    keep_owner;

  rr_pick #(
    .N    (NUM_MANAGERS),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i (ManagerReq),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh)
  );

  onehotdecoder #(
    .Width (NUM_MANAGERS),
    .IdxW  (IdxW)
  ) u_grant_dec (
    .onehot_i (grant_oh_q),
    .idx_o    (GrantIdx)
  );

  onehotdecoder #(
    .Width (NUM_MANAGERS),
    .IdxW  (IdxW)
  ) u_pick_dec (
    .onehot_i (pick_oh),
    .idx_o    (pick_idx)
  );

  // Mux the current owner's HTRANS/HMASTLOCK and summarise the request vector
  always_comb begin
    owner_trans = 2'b00;
    owner_lock  = 1'b0;
    for (int i = 0; i < NUM_MANAGERS; i++) begin
      owner_trans = owner_trans | (HTRANSM[2*i +: 2] & {2{grant_oh_q[i]}});
      owner_lock  = owner_lock | (HMASTLOCKM[i] & grant_oh_q[i]);
    end
    seq_busy   = (owner_trans == HtransSeq) || (owner_trans == HtransBusy);
    owner_req  = |(ManagerReq & grant_oh_q);
    others_req = |(ManagerReq & ~grant_oh_q);
    any_req    = |ManagerReq;
    pick_lock  = |(HMASTLOCKM & pick_oh);
    // Leaving a lock counts as an exhausted tenure so waiting managers win
    tenure_eff = (state_q == StLocked) ? MaxTen : tenure_q;
    keep_owner = owner_req && (!others_req || (tenure_eff < MaxTen));
  end

  // Next-state logic; every register holds while HREADY is low
  always_comb begin
    state_d      = state_q;
    grant_oh_d   = grant_oh_q;
    ptr_d        = ptr_q;
    tenure_d     = tenure_q;
    data_idx_d   = data_idx_q;
    data_valid_d = data_valid_q;

    if (HREADY) begin
      data_idx_d   = GrantIdx;
      data_valid_d = (owner_trans != HtransIdle);

      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_oh_d = pick_oh;
            ptr_d      = (pick_idx == IdxW'(NUM_MANAGERS - 1)) ? '0 : pick_idx + IdxW'(1);
            tenure_d   = '0;
            state_d    = pick_lock ? StLocked : StOwned;
          end
        end
        StOwned, StLocked: begin
          if (owner_lock) begin
            // Lock wins over a coincident boundary
            state_d = StLocked;
          end else if (!seq_busy) begin
            if (keep_owner) begin
              state_d  = StOwned;
              tenure_d = ((owner_trans == HtransNonseq) && (tenure_eff < MaxTen)) ?
                         tenure_eff + 8'd1 : tenure_eff;
            end else if (any_req) begin
              grant_oh_d = pick_oh;
              ptr_d      = (pick_idx == IdxW'(NUM_MANAGERS - 1)) ? '0 : pick_idx + IdxW'(1);
              tenure_d   = '0;
              state_d    = StOwned;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= StIdle;
      grant_oh_q   <= GrantRst;
      ptr_q        <= '0;
      tenure_q     <= '0;
      data_idx_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_oh_q   <= grant_oh_d;
      ptr_q        <= ptr_d;
      tenure_q     <= tenure_d;
      data_idx_q   <= data_idx_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign GrantOneHot  = grant_oh_q;
  assign GrantValid   = (state_q != StIdle);
  assign DataOwnerIdx = data_idx_q;
  assign DataValid    = data_valid_q;

  a_grant_onehot : assert property (@(posedge HCLK) disable iff (!HRESETn)
    $onehot(grant_oh_q));

  a_grant_idx : assert property (@(posedge HCLK) disable iff (!HRESETn)
    grant_oh_q[GrantIdx]);

  a_grant_stable : assert property (@(posedge HCLK) disable iff (!HRESETn)
    (!HREADY || (seq_busy && (state_q != StIdle))) |=> $stable(grant_oh_q));

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// Self-checking bench for ahb_manager_arbiter: directed scenarios plus randomized traffic.
module tb_ahb_manager_arbiter;

  localparam int N      = 4;
  localparam int MaxTen = 2;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] ManagerReq;
  logic [7:0] HTRANSM;
  logic [3:0] HMASTLOCKM;
  logic       HREADY;
  logic [3:0] GrantOneHot;
  logic [1:0] GrantIdx;
  logic       GrantValid;
  logic [1:0] DataOwnerIdx;
  logic       DataValid;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index, whether a live grant exists, lock, tenure, pointer
  int   m_owner;
  logic m_live;
  logic m_locked;
  int   m_ten;
  int   m_ptr;
  int   m_didx;
  logic m_dval;

  always #5 HCLK = ~HCLK;

  ahb_manager_arbiter #(
    .NUM_MANAGERS (N),
    .MAX_TENURE   (MaxTen)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .ManagerReq   (ManagerReq),
    .HTRANSM      (HTRANSM),
    .HMASTLOCKM   (HMASTLOCKM),
    .HREADY       (HREADY),
    .GrantOneHot  (GrantOneHot),
    .GrantIdx     (GrantIdx),
    .GrantValid   (GrantValid),
    .DataOwnerIdx (DataOwnerIdx),
    .DataValid    (DataValid)
  );

  function automatic int rr_ref(input logic [3:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (ptr + i) % N;
      if (req[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_live = 1'b0; m_locked = 1'b0; m_ten = 0; m_ptr = 0;
    m_didx = 0; m_dval = 1'b0;
  endtask

  task automatic model_grant(input logic [3:0] req);
    m_owner = rr_ref(req, m_ptr);
    m_ptr   = (m_owner + 1) % N;
    m_ten   = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    int         tr;
    logic       lk;
    int         ten;
    logic [3:0] others;
    if (!HRESETn || !HREADY) return;
    tr     = int'((HTRANSM >> (2 * m_owner)) & 8'h03);
    lk     = HMASTLOCKM[m_owner];
    m_didx = m_owner;
    m_dval = (tr != 0);
    if (!m_live) begin
      if (ManagerReq != 4'b0) begin
        model_grant(ManagerReq);
        m_live   = 1'b1;
        m_locked = HMASTLOCKM[m_owner];
      end
    end else if (lk) begin
      m_locked = 1'b1;
    end else if (tr == 1 || tr == 3) begin
      // owner mid-burst: hold
    end else begin
      ten      = m_locked ? MaxTen : m_ten;
      m_locked = 1'b0;
      others   = ManagerReq;
      others[m_owner] = 1'b0;
      if (ManagerReq[m_owner] && (others == 4'b0 || ten < MaxTen)) begin
        m_ten = (tr == 2 && ten < MaxTen) ? ten + 1 : ten;
      end else if (ManagerReq != 4'b0) begin
        model_grant(ManagerReq);
      end else begin
        m_live = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0; ManagerReq = '0; HTRANSM = '0; HMASTLOCKM = '0; HREADY = 1'b1;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) tick();
    total++; if (GrantOneHot !== 4'b0001) begin bad++;
      $display("FAIL reset_grant got=%b want=0001", GrantOneHot); end
    total++; if (GrantIdx !== 2'd0) begin bad++;
      $display("FAIL reset_idx got=%0d want=0", GrantIdx); end
    total++; if (GrantValid !== 1'b0) begin bad++;
      $display("FAIL reset_gvalid got=%b want=0", GrantValid); end
    total++; if (DataValid !== 1'b0) begin bad++;
      $display("FAIL reset_dvalid got=%b want=0", DataValid); end
  endtask

  task automatic test_pick_rr();
    ManagerReq = 4'b1010;
    tick();
    total++; if (GrantIdx !== 2'd1 || GrantValid !== 1'b1) begin bad++;
      $display("FAIL rr_first got=%0d/%b want=1/1", GrantIdx, GrantValid); end
    HTRANSM = 8'b0000_1000;
    tick();
    total++; if (GrantIdx !== 2'd1) begin bad++;
      $display("FAIL rr_keep got=%0d want=1", GrantIdx); end
    total++; if (DataValid !== 1'b1 || DataOwnerIdx !== 2'd1) begin bad++;
      $display("FAIL rr_data got=%b/%0d want=1/1", DataValid, DataOwnerIdx); end
    HTRANSM = '0; ManagerReq = 4'b1000;
    tick();
    total++; if (GrantOneHot !== 4'b1000) begin bad++;
      $display("FAIL rr_next got=%b want=1000", GrantOneHot); end
    // Pointer wrapped to 0, so manager 1 beats manager 2
    ManagerReq = 4'b0110;
    tick();
    total++; if (GrantIdx !== 2'd1) begin bad++;
      $display("FAIL rr_wrap got=%0d want=1", GrantIdx); end
    ManagerReq = 4'b0000;
    tick();
    total++; if (GrantValid !== 1'b0 || GrantOneHot !== 4'b0010) begin bad++;
      $display("FAIL rr_park got=%b/%b want=0/0010", GrantValid, GrantOneHot); end
  endtask

  task automatic test_burst_hready();
    logic [1:0] tr_seq [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       hr_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    ManagerReq = 4'b0011;
    tick();
    total++; if (GrantOneHot !== 4'b0001) begin bad++;
      $display("FAIL burst_start got=%b want=0001", GrantOneHot); end
    for (int i = 0; i < 6; i++) begin
      HTRANSM[1:0] = tr_seq[i];
      HREADY       = hr_seq[i];
      tick();
      total++; if (GrantOneHot !== 4'b0001) begin bad++;
        $display("FAIL burst_hold beat=%0d got=%b want=0001", i, GrantOneHot); end
      if (i == 1) begin
        total++; if (DataValid !== 1'b1 || DataOwnerIdx !== 2'd0) begin bad++;
          $display("FAIL burst_data_hold got=%b/%0d want=1/0", DataValid, DataOwnerIdx); end
      end
    end
    HTRANSM = '0; HREADY = 1'b1; ManagerReq = 4'b0010;
    tick();
    total++; if (GrantOneHot !== 4'b0010 || DataOwnerIdx !== 2'd0) begin bad++;
      $display("FAIL burst_handover got=%b/%0d want=0010/0", GrantOneHot, DataOwnerIdx); end
    tick();
    total++; if (DataOwnerIdx !== 2'd1 || DataValid !== 1'b0) begin bad++;
      $display("FAIL burst_data_lag got=%0d/%b want=1/0", DataOwnerIdx, DataValid); end
  endtask

  task automatic test_lock();
    do_reset();
    ManagerReq = 4'b0100; HMASTLOCKM = 4'b0100;
    tick();
    total++; if (GrantOneHot !== 4'b0100) begin bad++;
      $display("FAIL lock_grant got=%b want=0100", GrantOneHot); end
    ManagerReq = 4'b1111; HTRANSM[5:4] = 2'b10;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (GrantOneHot !== 4'b0100) begin bad++;
        $display("FAIL lock_hold n=%0d got=%b want=0100", i, GrantOneHot); end
    end
    HTRANSM = '0;
    tick();
    total++; if (GrantOneHot !== 4'b0100) begin bad++;
      $display("FAIL lock_idle_hold got=%b want=0100", GrantOneHot); end
    HMASTLOCKM = '0;
    tick();
    total++; if (GrantOneHot !== 4'b1000 || GrantValid !== 1'b1) begin bad++;
      $display("FAIL lock_release got=%b/%b want=1000/1", GrantOneHot, GrantValid); end
  endtask

  task automatic test_tenure();
    logic [3:0] want [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
    do_reset();
    ManagerReq = 4'b0101; HTRANSM = 8'b0000_0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (GrantOneHot !== want[i]) begin bad++;
        $display("FAIL tenure step=%0d got=%b want=%b", i, GrantOneHot, want[i]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ManagerReq = 4'b1000;
    tick();
    HTRANSM[7:6] = 2'b10;
    tick();
    HTRANSM[7:6] = 2'b11;
    tick();
    total++; if (GrantIdx !== 2'd3 || DataValid !== 1'b1) begin bad++;
      $display("FAIL areset_pre got=%0d/%b want=3/1", GrantIdx, DataValid); end
    HRESETn = 1'b0;
    #1;
    total++; if (GrantOneHot !== 4'b0001 || GrantIdx !== 2'd0) begin bad++;
      $display("FAIL areset_grant got=%b/%0d want=0001/0", GrantOneHot, GrantIdx); end
    total++; if (GrantValid !== 1'b0 || DataValid !== 1'b0) begin bad++;
      $display("FAIL areset_valid got=%b/%b want=0/0", GrantValid, DataValid); end
    model_reset();
    ManagerReq = '0; HTRANSM = '0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      ManagerReq = 4'($urandom);
      HTRANSM    = 8'($urandom);
      HMASTLOCKM = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      HREADY     = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (GrantOneHot !== 4'(1 << m_owner) || GrantIdx !== 2'(m_owner)) begin bad++;
        $display("FAIL rand_grant n=%0d got=%b want_idx=%0d", n, GrantOneHot, m_owner); end
      total++; if (GrantValid !== m_live) begin bad++;
        $display("FAIL rand_gvalid n=%0d got=%b want=%b", n, GrantValid, m_live); end
      total++; if (DataOwnerIdx !== 2'(m_didx) || DataValid !== m_dval) begin bad++;
        $display("FAIL rand_data n=%0d got=%0d/%b want=%0d/%b", n, DataOwnerIdx, DataValid,
                 m_didx, m_dval); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pick_rr();
    test_burst_hready();
    test_lock();
    test_tenure();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
